nmi_apb_bridge: RTL and testbench
=================================

Name: nmi_apb_bridge

Overview:
- Responder on the native memory interface (valid/ready/addr/wdata/wstrb/rdata). Initiator on an APB bus with wait states, slave error and write strobes.
- Sits behind the bus fabric's APB slave port and drives the APB peripheral cluster (UART1, PWM, PS2, SPFS, user IP).
- Converts one NMI transfer into exactly one APB transfer.
- Adds a timeout watchdog and error capture so that a hung or erroring peripheral never stalls the core.

Parameters:
- ADDR_WIDTH, 32, APB address width; low bits of the NMI address are forwarded.
- TIMEOUT, 255, maximum APB ACCESS cycles before a forced error completion. Must be >= 1.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a slave error or a timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- nmi_valid_i  in  1  transfer request
- nmi_addr_i  in  32  byte address
- nmi_wdata_i  in  32  write data
- nmi_wstrb_i  in  4  byte strobes; 0 = read
- nmi_ready_o  out  1  one-cycle completion pulse
- nmi_rdata_o  out  32  read data, valid while nmi_ready_o=1
- apb_paddr_o  out  ADDR_WIDTH  APB address, word aligned
- apb_psel_o  out  1  APB select
- apb_penable_o  out  1  APB enable
- apb_pwrite_o  out  1  APB write
- apb_pwdata_o  out  32  APB write data
- apb_pstrb_o  out  4  APB write strobes
- apb_pready_i  in  1  APB ready
- apb_prdata_i  in  32  APB read data
- apb_pslverr_i  in  1  APB slave error
- err_o  out  1  one-cycle pulse on a slave error or a timeout
- err_addr_o  out  32  address of the most recent errored transfer
- err_tmo_o  out  1  1 when the most recent error was a timeout, 0 when it was pslverr

Behaviour:
- Clock is clk_i only; reset is synchronous and active-high on rst_i.
- Reset values: FSM=IDLE; every output 0, including paddr, pwdata, pstrb, rdata, err_addr_o and err_tmo_o.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On nmi_valid_i=1, latch addr, wdata and wstrb; set pwrite=|wstrb; go to SETUP.
  - paddr = addr[ADDR_WIDTH-1:0] with bits [1:0] forced to 0.
  - pstrb = wstrb for writes, 0 for reads.
- SETUP: psel=1, penable=0; clear the timeout counter; go to ACCESS unconditionally. pready_i is ignored in this state.
- ACCESS: psel=1, penable=1; address, data and control are held stable.
  - pready_i=1: capture prdata_i and pslverr_i; go to RESP.
  - pready_i=0 and cnt==TIMEOUT-1: go to RESP with timeout flag set.
  - pready_i=0 otherwise: cnt++.
  - If pready_i arrives in the same cycle as the final count, pready wins and the transfer is not a timeout.
  - The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- RESP:
  - psel=0, penable=0, nmi_ready_o=1 for exactly one cycle.
  - nmi_rdata_o: captured prdata for a good read; ERR_RDATA for an errored read; 0 for any write.
  - On error: err_o=1 for this cycle; err_addr_o <= latched addr (full 32 bits); err_tmo_o <= timeout flag.
  - Go to IDLE.
- Next-cycle handshake: the master drops valid on the edge that samples ready, so IDLE in the following cycle sees valid=0 and no duplicate transfer is issued. Back-to-back transfers need one IDLE cycle between them.
- Latency: nmi_valid_i sampled at edge 0 leads to SETUP in cycle 1 and ACCESS in cycle 2. With a zero-wait slave, nmi_ready_o is high in cycle 3. Each APB wait state adds one cycle.
- Changes on the NMI inputs after latching (addr, wdata, wstrb, or a valid drop) are ignored until RESP.
- Writes with pslverr still complete on NMI; no retry.
- rst_i asserted in any state: the next cycle is IDLE with psel and penable low and no nmi_ready_o pulse. The in-flight transfer is abandoned, and the error registers are cleared.

Test Plan:
- Read, zero-wait: addr=0x0300_1006, prdata=0x1234_5678, pready=1 in ACCESS -> paddr=0x0300_1004, pwrite=0, nmi_ready_o high in cycle 3, rdata=0x1234_5678, err_o=0.
- Write, 2 wait states: wdata=0xA5A5_0F0F, wstrb=4'b0011 -> pwrite=1, pstrb=0011, pwdata stable for 3 ACCESS cycles, nmi_ready_o in cycle 5, rdata=0.
- Slave error on read: pslverr=1 with pready=1 at addr 0x0300_2000 -> rdata=0xDEAD_BEEF, err_o pulse, err_addr_o=0x0300_2000, err_tmo_o=0.
- Timeout with TIMEOUT=4: pready held 0 -> exactly 4 ACCESS cycles, then RESP with err_o=1 and err_tmo_o=1. Repeat with pready=1 on the 4th ACCESS cycle -> normal completion, no error.
- Reset mid-ACCESS: rst_i=1 during a wait state -> next cycle psel=0, penable=0, nmi_ready_o never pulses, err regs=0. A following read completes normally.
- Back-to-back: a read then a write issued as soon as the master allows -> exactly two APB transfers, one IDLE cycle between them, no duplicate transfer.

Source files
------------

// File: rtl/nmi_apb_bridge.sv
// -----------------------------------------------------------------------------
// nmi_apb_bridge
//
// Purpose:
//   Responder on the native memory interface (NMI) and initiator on APB. Each
//   accepted NMI request becomes exactly one APB transfer. The bridge holds the
//   APB SETUP/ACCESS phases, honours wait states and slave errors, and forces an
//   error completion if a peripheral never asserts pready. That way a hung or
//   failing peripheral can never stall the core.
//
// Parameters:
//   ADDR_WIDTH : APB address width. The low ADDR_WIDTH bits of the NMI address
//                are forwarded with bits [1:0] cleared. Must be 3..32.
//   TIMEOUT    : maximum number of ACCESS cycles before a forced error
//                completion. Must be >= 1.
//   ERR_RDATA  : read data returned for a slave error or a timeout.
//
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   nmi_valid_i           : transfer request
//   nmi_addr_i            : byte address
//   nmi_wdata_i           : write data
//   nmi_wstrb_i           : byte strobes (0 = read)
//   nmi_ready_o           : one-cycle completion pulse
//   nmi_rdata_o           : read data, valid while nmi_ready_o = 1
//   apb_paddr_o           : word-aligned APB address
//   apb_psel_o            : APB select
//   apb_penable_o         : APB enable
//   apb_pwrite_o          : APB write
//   apb_pwdata_o          : APB write data
//   apb_pstrb_o           : APB write strobes (0 for reads)
//   apb_pready_i          : APB ready
//   apb_prdata_i          : APB read data
//   apb_pslverr_i         : APB slave error
//   err_o                 : one-cycle pulse on a slave error or a timeout
//   err_addr_o            : full NMI address of the most recent errored transfer
//   err_tmo_o             : 1 if the most recent error was a timeout
//
// All outputs come straight from registers. Each output register is loaded
// with the value that belongs to the state being entered, so it is valid
// during the whole cycle spent in that state.
// -----------------------------------------------------------------------------
module nmi_apb_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // NMI responder
  input  logic                  nmi_valid_i,
  input  logic [31:0]           nmi_addr_i,
  input  logic [31:0]           nmi_wdata_i,
  input  logic [3:0]            nmi_wstrb_i,
  output logic                  nmi_ready_o,
  output logic [31:0]           nmi_rdata_o,
  // APB initiator
  output logic [ADDR_WIDTH-1:0] apb_paddr_o,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [31:0]           apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic                  apb_pready_i,
  input  logic [31:0]           apb_prdata_i,
  input  logic                  apb_pslverr_i,
  // Error capture
  output logic                  err_o,
  output logic [31:0]           err_addr_o,
  output logic                  err_tmo_o
);

  // The counter only has to reach TIMEOUT-1. It is sized for TIMEOUT so that
  // TIMEOUT = 1 still gets a legal, non-zero width.
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q,   state_d;
  logic [31:0]           addr_q,    addr_d;     // full address, kept for error capture
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [31:0]           pwdata_q,  pwdata_d;
  logic [3:0]            pstrb_q,   pstrb_d;
  logic                  pwrite_q,  pwrite_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  ready_q,   ready_d;
  logic [31:0]           rdata_q,   rdata_d;
  logic                  err_q,     err_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic                  err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  // Completion qualifiers for the ACCESS phase. pready has priority over the
  // final count, so a late but valid response is never reported as a timeout.
  logic acc_done;
  logic acc_tmo;
  logic acc_err;

  always_comb begin
    acc_done = apb_pready_i || (cnt_q == CNT_LAST);
    acc_tmo  = !apb_pready_i;
    acc_err  = apb_pready_i ? apb_pslverr_i : 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Hold the transfer context and the error record by default; the
    // per-cycle strobes fall back to 0.
    state_d    = state_q;
    addr_d     = addr_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    pwrite_d   = pwrite_q;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    ready_d    = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_tmo_d  = err_tmo_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (nmi_valid_i) begin
          state_d  = SETUP;
          addr_d   = nmi_addr_i;
          paddr_d  = {nmi_addr_i[ADDR_WIDTH-1:2], 2'b00};
          pwdata_d = nmi_wdata_i;
          pwrite_d = |nmi_wstrb_i;
          pstrb_d  = (|nmi_wstrb_i) ? nmi_wstrb_i : 4'b0000;
          psel_d   = 1'b1;
        end
      end

      SETUP: begin
        // pready is deliberately not looked at here: a slave may only
        // complete once penable is high.
        state_d   = ACCESS;
        cnt_d     = '0;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (acc_done) begin
          state_d = RESP;
          ready_d = 1'b1;
          // Writes always return 0. Errored reads return the marker value so
          // software sees a recognisable pattern instead of bus garbage.
          if (pwrite_q) begin
            rdata_d = '0;
          end else if (acc_err) begin
            rdata_d = ERR_RDATA;
          end else begin
            rdata_d = apb_prdata_i;
          end
          if (acc_err) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
            err_tmo_d  = acc_tmo;
          end
        end else begin
          // This branch is only reached while cnt_q < TIMEOUT-1, so the
          // increment can never wrap.
          cnt_d     = cnt_q + 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end

      RESP: begin
        // Back to IDLE no matter what valid looks like. The master drops
        // valid on the edge that samples ready, so the next IDLE cycle sees
        // either nothing or a genuinely new request.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pwrite_q   <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_tmo_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      pwrite_q   <= pwrite_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_tmo_q  <= err_tmo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign nmi_ready_o   = ready_q;
  assign nmi_rdata_o   = rdata_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;
  assign err_tmo_o     = err_tmo_q;

endmodule

// File: tb/tb_nmi_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_nmi_apb_bridge
//
// Directed bench for nmi_apb_bridge, built with TIMEOUT = 4. The bench plays
// both the NMI master and the APB slave. It drives inputs on the falling edge
// and samples outputs there too. Expected completions go into a scoreboard
// queue when a request is issued and are popped when nmi_ready_o pulses.
// -----------------------------------------------------------------------------
module tb_nmi_apb_bridge;

  localparam int          TMO    = 4;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        nmi_valid_i;
  logic [31:0] nmi_addr_i;
  logic [31:0] nmi_wdata_i;
  logic [3:0]  nmi_wstrb_i;
  logic        nmi_ready_o;
  logic [31:0] nmi_rdata_o;
  logic [31:0] apb_paddr_o;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic        apb_pwrite_o;
  logic [31:0] apb_pwdata_o;
  logic [3:0]  apb_pstrb_o;
  logic        apb_pready_i;
  logic [31:0] apb_prdata_i;
  logic        apb_pslverr_i;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_tmo_o;

  always #5 clk_i = ~clk_i;

  nmi_apb_bridge #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (TMO),
    .ERR_RDATA (ERR_RD)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .nmi_valid_i  (nmi_valid_i),
    .nmi_addr_i   (nmi_addr_i),
    .nmi_wdata_i  (nmi_wdata_i),
    .nmi_wstrb_i  (nmi_wstrb_i),
    .nmi_ready_o  (nmi_ready_o),
    .nmi_rdata_o  (nmi_rdata_o),
    .apb_paddr_o  (apb_paddr_o),
    .apb_psel_o   (apb_psel_o),
    .apb_penable_o(apb_penable_o),
    .apb_pwrite_o (apb_pwrite_o),
    .apb_pwdata_o (apb_pwdata_o),
    .apb_pstrb_o  (apb_pstrb_o),
    .apb_pready_i (apb_pready_i),
    .apb_prdata_i (apb_prdata_i),
    .apb_pslverr_i(apb_pslverr_i),
    .err_o        (err_o),
    .err_addr_o   (err_addr_o),
    .err_tmo_o    (err_tmo_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
    logic        err_tmo;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          setups_seen = 0;
  int          exp_setups = 0;
  logic [31:0] mdl_err_addr = '0;
  logic        mdl_err_tmo  = 1'b0;

  // Count SETUP phases the bridge actually puts on the bus. Values are read
  // before the NBA update of this edge, so each count refers to the cycle
  // that just ended.
  always @(posedge clk_i) begin
    if (apb_psel_o && !apb_penable_o) setups_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles with no request pending: the bridge must stay quiet.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk("idle_ready", 32'(nmi_ready_o), 32'd0);
      chk("idle_psel",  32'(apb_psel_o),  32'd0);
    end
  endtask

  // Issue one NMI transfer and act as the APB slave.
  //   waits     : ACCESS cycles before pready (0 = zero-wait), <0 = never ready
  //   setup_lat : cycles from issue to the SETUP phase (1 from IDLE, 2 when
  //               issued in the RESP cycle of the previous transfer)
  //   scramble  : after SETUP, drop valid and corrupt addr/wdata/wstrb
  // Starts at the current falling edge and returns at the falling edge of the
  // RESP cycle, with valid already dropped.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int waits, input logic slverr,
                      input logic [31:0] prdata, input int setup_lat, input bit scramble);
    exp_t        e;
    exp_t        got;
    logic        wr;
    logic        tmo;
    int          acc_exp;
    logic [31:0] paddr_exp;
    logic [3:0]  pstrb_exp;
    int          cyc;
    int          acc;

    wr        = |wstrb;
    tmo       = (waits < 0) || (waits >= TMO);
    acc_exp   = tmo ? TMO : waits + 1;
    paddr_exp = {addr[31:2], 2'b00};
    pstrb_exp = wr ? wstrb : 4'b0000;
    cyc       = 0;
    acc       = 0;

    e.err = tmo || slverr;
    if (e.err) begin
      mdl_err_addr = addr;
      mdl_err_tmo  = tmo;
    end
    e.rdata    = wr ? 32'd0 : (e.err ? ERR_RD : prdata);
    e.err_addr = mdl_err_addr;
    e.err_tmo  = mdl_err_tmo;
    sb_q.push_back(e);
    exp_setups++;

    nmi_valid_i  = 1'b1;
    nmi_addr_i   = addr;
    nmi_wdata_i  = wdata;
    nmi_wstrb_i  = wstrb;
    apb_pready_i = 1'b0;

    forever begin
      @(negedge clk_i);
      cyc++;
      if (cyc > 40) begin
        checks++;
        errors++;
        $error("FAIL ready_budget: no completion after %0d cycles, expected by cycle %0d",
               cyc, setup_lat + 1 + acc_exp);
        break;
      end
      if (apb_psel_o && !apb_penable_o) begin
        chk("setup_cycle",  32'(cyc),          32'(setup_lat));
        chk("setup_paddr",  apb_paddr_o,       paddr_exp);
        chk("setup_pwrite", 32'(apb_pwrite_o), 32'(wr));
        chk("setup_pstrb",  32'(apb_pstrb_o),  32'(pstrb_exp));
        if (wr) chk("setup_pwdata", apb_pwdata_o, wdata);
        // A spurious pready/pslverr during SETUP must be ignored.
        apb_pready_i  = 1'b1;
        apb_pslverr_i = 1'b1;
        apb_prdata_i  = 32'hFFFF_FFFF;
        if (scramble) begin
          nmi_valid_i = 1'b0;
          nmi_addr_i  = ~addr;
          nmi_wdata_i = ~wdata;
          nmi_wstrb_i = ~wstrb;
        end
      end else if (apb_psel_o && apb_penable_o) begin
        chk("access_paddr",  apb_paddr_o,       paddr_exp);
        chk("access_pwrite", 32'(apb_pwrite_o), 32'(wr));
        chk("access_pstrb",  32'(apb_pstrb_o),  32'(pstrb_exp));
        if (wr) chk("access_pwdata", apb_pwdata_o, wdata);
        apb_pready_i  = (waits >= 0) && (acc == waits);
        apb_pslverr_i = apb_pready_i ? slverr : 1'b0;
        apb_prdata_i  = apb_pready_i ? prdata : ~prdata;
        acc++;
      end else if (nmi_ready_o) begin
        chk("access_cycles", 32'(acc), 32'(acc_exp));
        chk("ready_cycle",   32'(cyc), 32'(setup_lat + 1 + acc_exp));
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: completion with no expected entry");
        end else begin
          got = sb_q.pop_front();
          chk("resp_rdata",    nmi_rdata_o,     got.rdata);
          chk("resp_err",      32'(err_o),      32'(got.err));
          chk("resp_err_addr", err_addr_o,      got.err_addr);
          chk("resp_err_tmo",  32'(err_tmo_o),  32'(got.err_tmo));
        end
        $display("xfer addr=%h wstrb=%b waits=%0d slverr=%0d -> rdata=%h err=%0d tmo=%0d cyc=%0d",
                 addr, wstrb, waits, slverr, nmi_rdata_o, err_o, err_tmo_o, cyc);
        nmi_valid_i   = 1'b0;
        apb_pready_i  = 1'b0;
        apb_pslverr_i = 1'b0;
        break;
      end else begin
        // Waiting in IDLE, e.g. the cycle after a previous RESP.
        chk("wait_err_pulse", 32'(err_o), 32'd0);
        apb_pready_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst_i         = 1'b1;
    nmi_valid_i   = 1'b0;
    nmi_addr_i    = '0;
    nmi_wdata_i   = '0;
    nmi_wstrb_i   = '0;
    apb_pready_i  = 1'b0;
    apb_prdata_i  = '0;
    apb_pslverr_i = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("rst_ready",    32'(nmi_ready_o),   32'd0);
    chk("rst_rdata",    nmi_rdata_o,        32'd0);
    chk("rst_paddr",    apb_paddr_o,        32'd0);
    chk("rst_psel",     32'(apb_psel_o),    32'd0);
    chk("rst_penable",  32'(apb_penable_o), 32'd0);
    chk("rst_pwrite",   32'(apb_pwrite_o),  32'd0);
    chk("rst_pwdata",   apb_pwdata_o,       32'd0);
    chk("rst_pstrb",    32'(apb_pstrb_o),   32'd0);
    chk("rst_err",      32'(err_o),         32'd0);
    chk("rst_err_addr", err_addr_o,         32'd0);
    chk("rst_err_tmo",  32'(err_tmo_o),     32'd0);
    rst_i = 1'b0;
    idle(2);

    // Zero-wait read, unaligned address.
    xfer(32'h0300_1006, 32'h0, 4'b0000, 0, 1'b0, 32'h1234_5678, 1, 1'b0);
    idle(1);
    // Write with two wait states; NMI inputs scrambled after latching.
    xfer(32'h0300_1010, 32'hA5A5_0F0F, 4'b0011, 2, 1'b0, 32'hFFFF_0000, 1, 1'b1);
    idle(1);
    // Read with slave error.
    xfer(32'h0300_2000, 32'h0, 4'b0000, 0, 1'b1, 32'h5555_AAAA, 1, 1'b0);
    idle(1);
    // Read timeout: pready never comes.
    xfer(32'h0300_3008, 32'h0, 4'b0000, -1, 1'b0, 32'h0, 1, 1'b0);
    idle(1);
    // pready on the final ACCESS cycle wins over the timeout.
    xfer(32'h0300_300C, 32'h0, 4'b0000, TMO - 1, 1'b0, 32'h0BAD_F00D, 1, 1'b0);
    idle(1);
    // Write timeout, then write with slave error after one wait state.
    xfer(32'h0300_4004, 32'h1111_2222, 4'b1111, -1, 1'b0, 32'h0, 1, 1'b0);
    idle(1);
    xfer(32'h0300_5000, 32'h3333_4444, 4'b1000, 1, 1'b1, 32'h0, 1, 1'b0);
    idle(1);

    // Reset during an ACCESS wait state; the error record is non-zero here.
    nmi_valid_i  = 1'b1;
    nmi_addr_i   = 32'h0300_6000;
    nmi_wstrb_i  = 4'b0000;
    apb_pready_i = 1'b0;
    exp_setups++;
    @(negedge clk_i);                 // SETUP
    nmi_valid_i = 1'b0;
    @(negedge clk_i);                 // ACCESS, wait
    @(negedge clk_i);                 // ACCESS, wait
    chk("pre_rst_penable", 32'(apb_penable_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_psel",     32'(apb_psel_o),    32'd0);
    chk("mid_rst_penable",  32'(apb_penable_o), 32'd0);
    chk("mid_rst_ready",    32'(nmi_ready_o),   32'd0);
    chk("mid_rst_err",      32'(err_o),         32'd0);
    chk("mid_rst_err_addr", err_addr_o,         32'd0);
    chk("mid_rst_err_tmo",  32'(err_tmo_o),     32'd0);
    rst_i        = 1'b0;
    mdl_err_addr = '0;
    mdl_err_tmo  = 1'b0;
    idle(4);
    xfer(32'h0300_7004, 32'h0, 4'b0000, 1, 1'b0, 32'hCAFE_0001, 1, 1'b0);
    idle(2);
    chk("setups_after_rst", 32'(setups_seen), 32'(exp_setups));

    // Back-to-back: the write is issued in the RESP cycle of the read.
    xfer(32'h0300_8000, 32'h0, 4'b0000, 0, 1'b0, 32'h7777_8888, 1, 1'b0);
    xfer(32'h0300_8004, 32'h9999_AAAA, 4'b1111, 0, 1'b0, 32'h0, 2, 1'b0);
    idle(4);
    chk("setups_total", 32'(setups_seen), 32'(exp_setups));
    chk("sb_empty",     32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
